// File: rtl/legv8_fetch_unit_if.sv
// Instruction-memory fetch channel: fetch unit drives request/address, memory returns data/valid.
interface legv8_fetch_unit_if #(
  parameter int PC_WIDTH = 64
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic                imem_valid;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_valid
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_valid
  );
endinterface

// File: rtl/legv8_fetch_unit.sv
// LEGv8 PC and instruction fetch: FETCH waits on imem_valid, EXEC applies ps/k/reg_a.
// Latency: 2 cycles per instruction at zero memory latency; memory stalls FETCH, ps=00 extends EXEC.
module legv8_fetch_unit #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          ps,
  input  logic [PC_WIDTH-1:0] k,
  input  logic [PC_WIDTH-1:0] reg_a,
  output logic [31:0]         I,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                exec_valid,
  legv8_fetch_unit_if.master  imem,
  output logic                fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_ir;
  logic                r_fault;
  logic [PC_WIDTH-1:0] w_pc_sel;
  logic                w_pc_load;

  // Branch base is the branch's own address, not pc+4.
  always_comb begin
    w_pc_sel = r_pc;
    case (ps)
      2'b01:   w_pc_sel = r_pc + PC_WIDTH'(4);
      2'b10:   w_pc_sel = reg_a;
      2'b11:   w_pc_sel = r_pc + (k << 2);
      default: w_pc_sel = r_pc;
    endcase
  end

  assign w_pc_load = (r_state == S_EXEC) && (ps != 2'b00);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (imem.imem_valid) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (ps != 2'b00) begin
          w_state_nxt = (w_pc_sel[1:0] != 2'b00) ? S_FAULT : S_FETCH;
        end
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    imem.imem_req  = 1'b0;
    exec_valid     = 1'b0;
    if (!reset) begin
      imem.imem_req = (r_state == S_FETCH);
      exec_valid    = (r_state == S_EXEC);
    end
  end

  // A misaligned target still loads into pc so it is visible when debugging the fault.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_ir    <= 32'h0;
      r_fault <= 1'b0;
    end else begin
      if ((r_state == S_FETCH) && imem.imem_valid) r_ir <= imem.imem_rdata;
      if (w_pc_load) r_pc <= w_pc_sel;
      if (w_state_nxt == S_FAULT) r_fault <= 1'b1;
    end
  end

  assign imem.imem_addr = r_pc;
  assign pc             = r_pc;
  assign pc_plus4       = r_pc + PC_WIDTH'(4);
  assign I              = r_ir;
  assign fault          = r_fault;

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Directed bench for legv8_fetch_unit with hand-computed expectations.
module tb_legv8_fetch_unit;

  localparam int PC_WIDTH = 64;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          ps = 2'b00;
  logic [PC_WIDTH-1:0] k = '0;
  logic [PC_WIDTH-1:0] reg_a = '0;
  logic [31:0]         I;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                exec_valid;
  logic                fault;

  int n_checks = 0;
  int n_fails  = 0;

  legv8_fetch_unit_if #(.PC_WIDTH(PC_WIDTH)) imem_bus ();

  legv8_fetch_unit #(
    .PC_WIDTH(PC_WIDTH),
    .RESET_PC(64'h0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ps         (ps),
    .k          (k),
    .reg_a      (reg_a),
    .I          (I),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .exec_valid (exec_valid),
    .imem       (imem_bus.master),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Complete a FETCH with a same-cycle valid; leaves the DUT in EXEC.
  task automatic do_fetch(input logic [31:0] data);
    imem_bus.imem_rdata = data;
    imem_bus.imem_valid = 1'b1;
    step();
    imem_bus.imem_valid = 1'b0;
  endtask

  task automatic do_exec(input logic [1:0] sel, input logic [63:0] kv, input logic [63:0] av);
    ps    = sel;
    k     = kv;
    reg_a = av;
    step();
    ps    = 2'b00;
  endtask

  initial begin
    imem_bus.imem_rdata = 32'h0;
    imem_bus.imem_valid = 1'b0;

    // 1: reset, same-cycle memory, ps=01
    reset = 1'b1;
    step();
    check_val("rst_req", 64'(imem_bus.imem_req), 64'd0);
    check_val("rst_xv", 64'(exec_valid), 64'd0);
    check_val("rst_pc", pc, 64'h0);
    check_val("rst_ir", 64'(I), 64'h0);
    check_val("rst_fault", 64'(fault), 64'd0);
    reset = 1'b0;
    #1;
    check_val("t1_req", 64'(imem_bus.imem_req), 64'd1);
    check_val("t1_addr", imem_bus.imem_addr, 64'h0);
    ps = 2'b01;
    do_fetch(32'h8B020020);
    check_val("t1_xv", 64'(exec_valid), 64'd1);
    check_val("t1_I", 64'(I), 64'h8B020020);
    check_val("t1_p4", pc_plus4, 64'h4);
    ps = 2'b01;
    step();
    ps = 2'b00;
    check_val("t1_addr4", imem_bus.imem_addr, 64'h4);
    check_val("t1_req4", 64'(imem_bus.imem_req), 64'd1);
    check_val("t1_xv4", 64'(exec_valid), 64'd0);
    check_val("t1_Ikeep", 64'(I), 64'h8B020020);

    // 2: delayed memory at 0x40
    do_fetch(32'h11111111);
    do_exec(2'b10, 64'h0, 64'h40);
    for (int i = 0; i < 5; i++) begin
      check_val("t2_req", 64'(imem_bus.imem_req), 64'd1);
      check_val("t2_addr", imem_bus.imem_addr, 64'h40);
      check_val("t2_xv", 64'(exec_valid), 64'd0);
      step();
    end
    check_val("t2_req6", 64'(imem_bus.imem_req), 64'd1);
    check_val("t2_addr6", imem_bus.imem_addr, 64'h40);
    do_fetch(32'h22222222);
    check_val("t2_xv", 64'(exec_valid), 64'd1);
    check_val("t2_I", 64'(I), 64'h22222222);

    // 3: relative branches from 0x100
    do_exec(2'b10, 64'h0, 64'h100);
    do_fetch(32'h33333333);
    check_val("t3_pc", pc, 64'h100);
    do_exec(2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
    check_val("t3_neg", imem_bus.imem_addr, 64'hF8);
    check_val("t3_negreq", 64'(imem_bus.imem_req), 64'd1);
    do_fetch(32'h44444444);
    do_exec(2'b10, 64'h0, 64'h100);
    do_fetch(32'h55555555);
    do_exec(2'b11, 64'h3, 64'h0);
    check_val("t3_pos", imem_bus.imem_addr, 64'h10C);

    // 4: ps=00 hold, then PC+4; then register target
    do_fetch(32'h66666666);
    do_exec(2'b10, 64'h0, 64'h20);
    do_fetch(32'hAAAA5555);
    for (int i = 0; i < 3; i++) begin
      check_val("t4_xv", 64'(exec_valid), 64'd1);
      check_val("t4_I", 64'(I), 64'hAAAA5555);
      check_val("t4_pc", pc, 64'h20);
      if (i < 2) step();
    end
    do_exec(2'b01, 64'h0, 64'h0);
    check_val("t4_addr", imem_bus.imem_addr, 64'h24);
    check_val("t4_req", 64'(imem_bus.imem_req), 64'd1);
    do_fetch(32'h77777777);
    do_exec(2'b10, 64'h0, 64'h1000);
    check_val("t4_br", imem_bus.imem_addr, 64'h1000);

    // 5: misaligned register target, sticky fault, reset clears
    do_fetch(32'h88888888);
    do_exec(2'b10, 64'h0, 64'h1002);
    check_val("t5_fault", 64'(fault), 64'd1);
    check_val("t5_pc", pc, 64'h1002);
    check_val("t5_xv", 64'(exec_valid), 64'd0);
    imem_bus.imem_valid = 1'b1;
    ps = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("t5_req", 64'(imem_bus.imem_req), 64'd0);
      check_val("t5_hold", 64'(fault), 64'd1);
    end
    imem_bus.imem_valid = 1'b0;
    ps = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_val("t5_clr", 64'(fault), 64'd0);
    check_val("t5_rpc", imem_bus.imem_addr, 64'h0);
    check_val("t5_rreq", 64'(imem_bus.imem_req), 64'd1);

    // 6: reset during FETCH wait (late valid ignored) and during EXEC hold
    do_fetch(32'h99999999);
    do_exec(2'b01, 64'h0, 64'h0);
    step();
    step();
    reset = 1'b1;
    imem_bus.imem_rdata = 32'hDEADBEEF;
    imem_bus.imem_valid = 1'b1;
    #1;
    check_val("t6_rreq", 64'(imem_bus.imem_req), 64'd0);
    step();
    reset = 1'b0;
    imem_bus.imem_valid = 1'b0;
    #1;
    check_val("t6_I", 64'(I), 64'h0);
    check_val("t6_pc", pc, 64'h0);
    check_val("t6_req", 64'(imem_bus.imem_req), 64'd1);
    check_val("t6_xv", 64'(exec_valid), 64'd0);
    do_fetch(32'h12345678);
    step();
    check_val("t6_hold", 64'(exec_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_val("t6_I2", 64'(I), 64'h0);
    check_val("t6_pc2", pc, 64'h0);
    check_val("t6_req2", 64'(imem_bus.imem_req), 64'd1);
    check_val("t6_xv2", 64'(exec_valid), 64'd0);

    // Address wrap: pc+4 from all-ones-minus-3 is 0, no fault
    do_fetch(32'hCAFEF00D);
    do_exec(2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    check_val("wr_p4", pc_plus4, 64'h0);
    do_fetch(32'h0BADF00D);
    do_exec(2'b01, 64'h0, 64'h0);
    check_val("wr_addr", imem_bus.imem_addr, 64'h0);
    check_val("wr_fault", 64'(fault), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
